// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage and its cache.
package inst_fetcher_pkg;

  typedef logic [31:0] DATA_TYPE;

  localparam logic     TRUE      = 1'b1;
  localparam logic     FALSE     = 1'b0;
  localparam DATA_TYPE ZERO_WORD = 32'h0000_0000;

  // Default cache geometry: 2^8 lines of one word each.
  localparam int ICACHE_INDEX_W_DEFAULT = 8;

  // Tag covers every PC bit above the index and the byte offset.
  function automatic int icache_tag_width(input int index_w);
    return 32 - index_w - 2;
  endfunction

  localparam int ICACHE_TAG_W_DEFAULT = icache_tag_width(ICACHE_INDEX_W_DEFAULT);

  // Fetch FSM encoding.
  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_MISS_WAIT = 1'b1;

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetcher bus: memory-controller request/response, issue delivery and ROB redirect.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic     out_mem_flag;
  DATA_TYPE out_mem_addr;
  logic     in_mem_flag;
  DATA_TYPE in_mem_data;
  logic     in_issue_full;
  logic     out_inst_flag;
  DATA_TYPE out_inst;
  DATA_TYPE out_pc;
  logic     in_rob_xbp;
  DATA_TYPE in_rob_target;

  // Fetch stage side.
  modport master (
    output out_mem_flag, out_mem_addr, out_inst_flag, out_inst, out_pc,
    input  in_mem_flag, in_mem_data, in_issue_full, in_rob_xbp, in_rob_target
  );

  // Surrounding pipeline side (memory controller, issue, ROB).
  modport slave (
    input  out_mem_flag, out_mem_addr, out_inst_flag, out_inst, out_pc,
    output in_mem_flag, in_mem_data, in_issue_full, in_rob_xbp, in_rob_target
  );

endinterface

// File: rtl/inst_fetcher_icache_array.sv
// Direct-mapped instruction cache storage: one word per line,
// combinational lookup, single write port, valid bits cleared on reset.
module icache_array
  import inst_fetcher_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W_DEFAULT,
  parameter int TAG_W   = icache_tag_width(INDEX_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               rd_hit_o,
  output DATA_TYPE           rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  DATA_TYPE           wr_data_i
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  DATA_TYPE         data_q [LINES];

  // One valid bit per line: cleared only by reset, set when that line is filled.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[gi] <= FALSE;
      end else if (wr_en_i && (wr_index_i == INDEX_W'(gi))) begin
        valid_q[gi] <= TRUE;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_index_i];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: PC, miss FSM and memory handshake around a
// direct-mapped one-word-per-line instruction cache.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int       ICACHE_INDEX_W = ICACHE_INDEX_W_DEFAULT,
  parameter DATA_TYPE RESET_PC       = ZERO_WORD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  inst_fetcher_if.master bus
);

  localparam int TAG_W = icache_tag_width(ICACHE_INDEX_W);

  logic [0:0] state_q, state_d;
  DATA_TYPE   pc_q, pc_d;
  logic       mem_flag_q, mem_flag_d;
  DATA_TYPE   mem_addr_q, mem_addr_d;
  logic       inst_flag_q, inst_flag_d;
  DATA_TYPE   inst_q, inst_d;
  DATA_TYPE   out_pc_q, out_pc_d;

  logic       cache_hit;
  DATA_TYPE   cache_data;
  logic       fill_en;

  // Lookup uses the current PC; the fill uses the address that missed.
  icache_array #(
    .INDEX_W (ICACHE_INDEX_W),
    .TAG_W   (TAG_W)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (pc_q[ICACHE_INDEX_W+1:2]),
    .rd_tag_i   (pc_q[31:ICACHE_INDEX_W+2]),
    .rd_hit_o   (cache_hit),
    .rd_data_o  (cache_data),
    .wr_en_i    (fill_en && !rst),
    .wr_index_i (mem_addr_q[ICACHE_INDEX_W+1:2]),
    .wr_tag_i   (mem_addr_q[31:ICACHE_INDEX_W+2]),
    .wr_data_i  (bus.in_mem_data)
  );

  // Next-state: redirect beats everything, then hit/miss in IDLE or fill in MISS_WAIT.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_flag_d  = mem_flag_q;
    mem_addr_d  = mem_addr_q;
    inst_flag_d = inst_flag_q;
    inst_d      = inst_q;
    out_pc_d    = out_pc_q;
    fill_en     = FALSE;

    if (rdy) begin
      // Both flags are single-cycle pulses.
      mem_flag_d  = FALSE;
      inst_flag_d = FALSE;

      if (bus.in_rob_xbp) begin
        // Any outstanding read is dropped by the controller, and a response
        // landing in this same cycle is discarded without filling.
        pc_d    = bus.in_rob_target;
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        if (!bus.in_issue_full) begin
          if (cache_hit) begin
            inst_flag_d = TRUE;
            inst_d      = cache_data;
            out_pc_d    = pc_q;
            pc_d        = pc_q + 32'd4;
          end else begin
            mem_flag_d = TRUE;
            mem_addr_d = pc_q;
            state_d    = ST_MISS_WAIT;
          end
        end
      end else if (bus.in_mem_flag) begin
        // Issue keeps a slot free for this, so in_issue_full is not consulted.
        fill_en     = TRUE;
        inst_flag_d = TRUE;
        inst_d      = bus.in_mem_data;
        out_pc_d    = mem_addr_q;
        pc_d        = pc_q + 32'd4;
        state_d     = ST_IDLE;
      end
    end
  end

  // State and output registers; rdy low is already folded into the _d hold values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      mem_flag_q  <= FALSE;
      mem_addr_q  <= ZERO_WORD;
      inst_flag_q <= FALSE;
      inst_q      <= ZERO_WORD;
      out_pc_q    <= ZERO_WORD;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_flag_q  <= mem_flag_d;
      mem_addr_q  <= mem_addr_d;
      inst_flag_q <= inst_flag_d;
      inst_q      <= inst_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign bus.out_mem_flag  = mem_flag_q;
  assign bus.out_mem_addr  = mem_addr_q;
  assign bus.out_inst_flag = inst_flag_q;
  assign bus.out_inst      = inst_q;
  assign bus.out_pc        = out_pc_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Testbench for inst_fetcher: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

  localparam int LINES = 256;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  inst_fetcher_if bus();

  inst_fetcher #(.ICACHE_INDEX_W(8), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory image: a scrambled function of the word address, 0x13 at address 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 32'(LINES));
  endfunction

  // ---------------- behavioural model ----------------
  logic        m_live = 1'b0;
  logic [31:0] m_pc;
  logic        m_wait;
  logic [31:0] m_miss_addr;
  logic        m_valid     [LINES];
  logic [31:0] m_line_addr [LINES];
  logic [31:0] m_line_data [LINES];
  logic        e_mem_flag, e_inst_flag;
  logic [31:0] e_mem_addr, e_inst, e_pc;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_live = 1'b1; m_pc = 32'h0; m_wait = 1'b0; m_miss_addr = 32'h0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        e_mem_flag = 1'b0; e_mem_addr = 32'h0;
        e_inst_flag = 1'b0; e_inst = 32'h0; e_pc = 32'h0;
      end else if (rdy && m_live) begin
        e_mem_flag  = 1'b0;
        e_inst_flag = 1'b0;
        if (bus.in_rob_xbp) begin
          m_pc   = bus.in_rob_target;
          m_wait = 1'b0;
        end else if (m_wait) begin
          if (bus.in_mem_flag) begin
            m_valid[line_of(m_miss_addr)]     = 1'b1;
            m_line_addr[line_of(m_miss_addr)] = m_miss_addr;
            m_line_data[line_of(m_miss_addr)] = bus.in_mem_data;
            e_inst_flag = 1'b1;
            e_inst      = bus.in_mem_data;
            e_pc        = m_miss_addr;
            m_pc        = m_miss_addr + 32'd4;
            m_wait      = 1'b0;
          end
        end else if (!bus.in_issue_full) begin
          if (m_valid[line_of(m_pc)] && m_line_addr[line_of(m_pc)] == m_pc) begin
            e_inst_flag = 1'b1;
            e_inst      = m_line_data[line_of(m_pc)];
            e_pc        = m_pc;
            m_pc        = m_pc + 32'd4;
          end else begin
            e_mem_flag  = 1'b1;
            e_mem_addr  = m_pc;
            m_miss_addr = m_pc;
            m_wait      = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        checks++;
        if (bus.out_mem_flag !== e_mem_flag || bus.out_mem_addr !== e_mem_addr ||
            bus.out_inst_flag !== e_inst_flag || bus.out_inst !== e_inst ||
            bus.out_pc !== e_pc) begin
          errors++;
          $display("FAIL cycle_model t=%0t got mem=%b/%h inst=%b/%h pc=%h expected mem=%b/%h inst=%b/%h pc=%h",
                   $time, bus.out_mem_flag, bus.out_mem_addr, bus.out_inst_flag, bus.out_inst,
                   bus.out_pc, e_mem_flag, e_mem_addr, e_inst_flag, e_inst, e_pc);
        end
      end
    end
  end

  // ---------------- memory controller stand-in and driver ----------------
  logic        resp_pending = 1'b0;
  logic [31:0] resp_addr    = 32'h0;
  int          resp_cnt     = 0;
  int          n_req        = 0;
  logic        stale_en     = 1'b0;
  logic        xbp_on_resp  = 1'b0;
  logic [31:0] xbp_resp_target = 32'h0;
  logic        hit_resp_xbp = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: present inputs, take the edge, then track requests/responses.
  task automatic tick();
    bus.in_mem_flag = 1'b0;
    bus.in_mem_data = $urandom;
    if (rdy && resp_pending && resp_cnt == 0) begin
      bus.in_mem_flag = 1'b1;
      bus.in_mem_data = mem_word(resp_addr);
      if (xbp_on_resp) begin
        bus.in_rob_xbp    = 1'b1;
        bus.in_rob_target = xbp_resp_target;
        xbp_on_resp       = 1'b0;
        hit_resp_xbp      = 1'b1;
      end
    end else if (rdy && !resp_pending && stale_en && $urandom_range(0, 49) == 0) begin
      bus.in_mem_flag = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      resp_pending = 1'b0;
    end else if (rdy) begin
      if (bus.in_rob_xbp || (bus.in_mem_flag && resp_pending)) resp_pending = 1'b0;
      else if (resp_pending && resp_cnt > 0) resp_cnt--;
      if (bus.out_mem_flag) begin
        resp_pending = 1'b1;
        resp_addr    = bus.out_mem_addr;
        resp_cnt     = 5 + int'($urandom_range(0, 3));
        n_req++;
      end
    end
    bus.in_rob_xbp  = 1'b0;
    bus.in_mem_flag = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.in_rob_xbp    = 1'b1;
    bus.in_rob_target = target;
    tick();
  endtask

  task automatic wait_inst(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (bus.out_inst_flag) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no out_inst_flag expected one within 40 cycles", name);
    end
  endtask

  initial begin
    int req_before;
    rst = 1'b1; rdy = 1'b1;
    bus.in_mem_flag = 1'b0; bus.in_mem_data = 32'h0; bus.in_issue_full = 1'b0;
    bus.in_rob_xbp = 1'b0; bus.in_rob_target = 32'h0;
    tick(); tick();
    chk("rst_mem_flag", 32'(bus.out_mem_flag), 32'h0);
    chk("rst_mem_addr", bus.out_mem_addr, 32'h0);
    chk("rst_inst_flag", 32'(bus.out_inst_flag), 32'h0);
    chk("rst_inst", bus.out_inst, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    rst = 1'b0;

    // Cold start: miss at 0, fill, then sequential misses at 4, 8, 0xC.
    tick();
    chk("cold_req_flag", 32'(bus.out_mem_flag), 32'h1);
    chk("cold_req_addr", bus.out_mem_addr, 32'h0);
    req_before = n_req;
    wait_inst("cold");
    chk("cold_inst", bus.out_inst, 32'h0000_0013);
    chk("cold_pc", bus.out_pc, 32'h0);
    chk("cold_one_req", 32'(n_req - req_before), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("seq_req_flag", 32'(bus.out_mem_flag), 32'h1);
      chk("seq_req_addr", bus.out_mem_addr, 32'(4 * k));
      wait_inst("seq");
      chk("seq_pc", bus.out_pc, 32'(4 * k));
    end

    // Loop refetch 0x0..0xC: four back-to-back hits.
    redirect(32'h0);
    chk("xbp_no_inst", 32'(bus.out_inst_flag), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("loop_inst_flag", 32'(bus.out_inst_flag), 32'h1);
      chk("loop_pc", bus.out_pc, 32'(4 * i));
      chk("loop_inst", bus.out_inst, mem_word(32'(4 * i)));
      chk("loop_no_req", 32'(bus.out_mem_flag), 32'h0);
    end

    // Conflict: 0x400 evicts 0x000, so 0x000 misses again.
    redirect(32'h400);
    tick();
    chk("conf_req_addr", bus.out_mem_addr, 32'h400);
    wait_inst("conf");
    chk("conf_pc", bus.out_pc, 32'h400);
    redirect(32'h0);
    tick();
    chk("conf_remiss_flag", 32'(bus.out_mem_flag), 32'h1);
    chk("conf_remiss_addr", bus.out_mem_addr, 32'h0);
    wait_inst("conf_refill");
    chk("conf_refill_pc", bus.out_pc, 32'h0);

    // Redirect coinciding with the fill response for 0x800.
    redirect(32'h800);
    tick();
    chk("xr_req_addr", bus.out_mem_addr, 32'h800);
    xbp_on_resp = 1'b1; xbp_resp_target = 32'h100; hit_resp_xbp = 1'b0;
    for (int i = 0; i < 20 && !hit_resp_xbp; i++) tick();
    chk("xr_happened", 32'(hit_resp_xbp), 32'h1);
    chk("xr_no_inst", 32'(bus.out_inst_flag), 32'h0);
    tick();
    chk("xr_req_flag", 32'(bus.out_mem_flag), 32'h1);
    chk("xr_req_addr2", bus.out_mem_addr, 32'h100);
    wait_inst("xr");
    chk("xr_pc", bus.out_pc, 32'h100);
    redirect(32'h0);
    tick();
    chk("xr_nofill_hit", 32'(bus.out_inst_flag), 32'h1);
    chk("xr_nofill_pc", bus.out_pc, 32'h0);

    // Issue full for three cycles in a hit stream.
    bus.in_issue_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_no_inst", 32'(bus.out_inst_flag), 32'h0);
      chk("full_no_req", 32'(bus.out_mem_flag), 32'h0);
    end
    bus.in_issue_full = 1'b0;
    tick();
    chk("full_resume_flag", 32'(bus.out_inst_flag), 32'h1);
    chk("full_resume_pc", bus.out_pc, 32'h4);

    // rdy low for four cycles while a miss is outstanding.
    redirect(32'h200);
    tick();
    chk("rdy_req_addr", bus.out_mem_addr, 32'h200);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rdy_no_pulse", 32'(bus.out_mem_flag), 32'h0);
      chk("rdy_addr_hold", bus.out_mem_addr, 32'h200);
    end
    rdy = 1'b1;
    req_before = n_req;
    wait_inst("rdy");
    chk("rdy_pc", bus.out_pc, 32'h200);
    chk("rdy_no_rereq", 32'(n_req - req_before), 32'h0);

    // PC wraps from 0xFFFFFFFC to 0, which is cached.
    redirect(32'hFFFF_FFFC);
    tick();
    chk("wrap_req_addr", bus.out_mem_addr, 32'hFFFF_FFFC);
    wait_inst("wrap");
    tick();
    chk("wrap_hit_flag", 32'(bus.out_inst_flag), 32'h1);
    chk("wrap_hit_pc", bus.out_pc, 32'h0);

    // Randomized traffic against the model.
    stale_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      bus.in_issue_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) begin
        bus.in_rob_xbp = 1'b1;
        case ($urandom_range(0, 3))
          0:       bus.in_rob_target = 32'($urandom_range(0, 127)) << 2;
          1:       bus.in_rob_target = 32'h400 + (32'($urandom_range(0, 63)) << 2);
          2:       bus.in_rob_target = 32'h8000_0000 + (32'($urandom_range(0, 63)) << 2);
          default: bus.in_rob_target = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
        endcase
      end
      tick();
    end
    rst = 1'b0; rdy = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
